mm2s_packet_router: RTL and testbench
=====================================

# mm2s_packet_router

Packet-aware successor to the MCDMA mm2s stream splitter. It sits between the MCDMA master mm2s AXI Stream port and NUM_FIFOS accelerator sink FIFOs. It latches the destination on the first beat of each packet and holds that route until `tlast`. A registered output stage gives one beat per cycle of throughput, and packets addressed to a non-existent FIFO are drained and counted.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 32: input stream data width.
- `FIFO_DATA_WIDTH`, 32: sink FIFO data width; must be ≤ AXIS_DATA_WIDTH; the lower bits are forwarded.
- `AXIS_DEST_WIDTH`, 4: tdest width.
- `NUM_FIFOS`, 4: sink channel count, 1..2^AXIS_DEST_WIDTH.
- `CNT_WIDTH`, 16: width of the status counters.

Ports:
- `clk`  in  1  clock; one clock domain.
- `rstn`  in  1  reset, asynchronous, active-low.
- `SRC_AXIS_tdata`  in  AXIS_DATA_WIDTH  stream data.
- `SRC_AXIS_tdest`  in  AXIS_DEST_WIDTH  destination; sampled on the first beat only.
- `SRC_AXIS_tlast`  in  1  end of packet.
- `SRC_AXIS_tvalid`  in  1  beat valid.
- `SRC_AXIS_tready`  out  1  beat accepted when tvalid and tready are both high.
- `fifo_wren`  out  NUM_FIFOS  one-hot write enable.
- `fifo_full`  in  NUM_FIFOS  per-sink full flag.
- `fifo_data`  out  FIFO_DATA_WIDTH  write data, shared by all sinks.
- `busy`  out  1  high while a packet is open (ROUTE or DRAIN).
- `drop_count`  out  CNT_WIDTH  beats discarded for an invalid tdest; saturates at its maximum value.
- `pkt_count`  out  NUM_FIFOS*CNT_WIDTH  packets completed per channel; channel i occupies bits [i*CNT_WIDTH +: CNT_WIDTH]. Present as described only when stats are compiled in.

## Operation
State machine:
- IDLE: waiting for the first beat of a packet.
  - Beat accepted with tdest < NUM_FIFOS: latch `cur_dest` ← tdest and load the beat into the output register. Go to ROUTE unless the beat has tlast, in which case stay in IDLE.
  - Beat accepted with tdest ≥ NUM_FIFOS: discard it and increment drop_count. Go to DRAIN unless the beat has tlast.
- ROUTE: every accepted beat goes to `cur_dest`, regardless of its tdest. Return to IDLE on the beat with tlast.
- DRAIN: tready=1 unconditionally. Each beat is discarded and increments drop_count. Return to IDLE on the beat with tlast.

Output register:
- Holds `out_valid`, `out_dest` and `out_data`.
- `fifo_wren[i] = out_valid && out_dest==i && !fifo_full[i]`; this is the write-fire condition.
- `fifo_data = out_data[FIFO_DATA_WIDTH-1:0]`.
- Outside DRAIN, `SRC_AXIS_tready = !out_valid || fire`, where `fire` is the write firing this cycle. This is a combinational path from fifo_full to tready and is accepted.
- On accept, the register loads the new beat. If the write fires and nothing is accepted, out_valid clears. A full sink stalls only its own packet; the beat is held until space is available.

Other rules:
- `busy` is high in ROUTE and DRAIN.
- pkt_count[i] increments, saturating, when a beat with tlast is accepted for channel i.

## Timing
- Reset values: out_valid=0, state=IDLE, fifo_wren=0, fifo_data=0, tready=1, busy=0, drop_count=0, pkt_count=0.
- Latency: a beat accepted in cycle n produces fifo_wren in cycle n+1 at the earliest.
- Throughput: one beat per cycle while the destination is not full.
- Full at write time: wren is held low and the data is held. The write occurs in the first cycle in which full is low.
- Full rises while a write is pending: no write occurs, because wren is gated by the current full flag, so overflow is impossible.
- Single-beat packets (tlast on the first beat) are valid; the state stays in IDLE.
- tdest changes mid-packet: ignored.
- tvalid drops mid-packet: the state is held and no timeout applies.
- Reset asserted mid-packet: all state clears immediately. A pending output beat is lost, and the remainder of an interrupted packet is treated as a new packet.
- drop_count at its maximum value stays at that value.

## Configuration
- `MM2S_ROUTER_STATS_EN` defined: the pkt_count registers and their increment logic are compiled in.
- Not defined: pkt_count is tied to 0 and no registers are generated. All other behaviour, including drop_count, is unchanged.

## Test plan
- 4-beat packet to tdest=2 with sinks never full: wren[2] pulses on cycles 1..4 after the first accept, data matches, tready stays 1, and pkt_count[2]=1.
- Same packet but with tdest changed to 0 on beat 3: all 4 beats still go to sink 2 and wren[0] never asserts.
- Packet to tdest=1 with fifo_full[1] held high for 5 cycles starting at beat 2: tready drops within the same cycle as full, no wren while full, no beat lost or duplicated, and the sequence resumes intact.
- NUM_FIFOS=4, 3-beat packet with tdest=9, then a 1-beat packet to tdest=0: no wren during the first packet, drop_count=3, wren[0] fires exactly once, busy high only during DRAIN.
- Back-to-back single-beat packets to 0,1,2,3 on consecutive cycles: wren is one-hot in the order 1,2,4,8 with no bubbles, and busy stays 0.
- Reset pulse during beat 2 of a 4-beat packet: all outputs return to reset values, and the next beat is routed by its own tdest.

Source files
------------

// File: rtl/mm2s_packet_router.sv
// Routes MCDMA mm2s AXI Stream packets to NUM_FIFOS sink FIFOs by first-beat tdest; invalid tdest packets are drained.
// Latency: one cycle from accept to fifo_wren. Backpressure: a full sink drops tready combinationally; DRAIN always ready.
// Optional: MM2S_ROUTER_STATS_EN compiles in per-channel completed-packet counters (pkt_count).
module mm2s_packet_router #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_FIFOS       = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [AXIS_DATA_WIDTH-1:0]     SRC_AXIS_tdata,
    input  logic [AXIS_DEST_WIDTH-1:0]     SRC_AXIS_tdest,
    input  logic                           SRC_AXIS_tlast,
    input  logic                           SRC_AXIS_tvalid,
    output logic                           SRC_AXIS_tready,
    output logic [NUM_FIFOS-1:0]           fifo_wren,
    input  logic [NUM_FIFOS-1:0]           fifo_full,
    output logic [FIFO_DATA_WIDTH-1:0]     fifo_data,
    output logic                           busy,
    output logic [CNT_WIDTH-1:0]           drop_count,
    output logic [NUM_FIFOS*CNT_WIDTH-1:0] pkt_count
);

    // One extra bit so NUM_FIFOS == 2**AXIS_DEST_WIDTH is representable.
    localparam logic [AXIS_DEST_WIDTH:0] NUM_FIFOS_W = (AXIS_DEST_WIDTH+1)'(NUM_FIFOS);
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX     = {CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [AXIS_DEST_WIDTH-1:0] cur_dest;
    logic [AXIS_DEST_WIDTH-1:0] load_dest;
    logic                       out_valid;
    logic [AXIS_DEST_WIDTH-1:0] out_dest;
    logic [AXIS_DATA_WIDTH-1:0] out_data;
    logic                       fire;
    logic                       accept;
    logic                       dest_ok;
    logic                       load;
    logic                       drop;

    // Write enable is gated by the live full flag, so a sink can never be overfilled.
    always_comb begin
        fifo_wren = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            fifo_wren[i] = out_valid && (out_dest == AXIS_DEST_WIDTH'(i)) && !fifo_full[i];
        end
    end

    assign fire            = |fifo_wren;
    assign fifo_data       = out_data[FIFO_DATA_WIDTH-1:0];
    assign dest_ok         = ({1'b0, SRC_AXIS_tdest} < NUM_FIFOS_W);
    assign SRC_AXIS_tready = (state == DRAIN) || !out_valid || fire;
    assign accept          = SRC_AXIS_tvalid && SRC_AXIS_tready;
    assign busy            = (state != IDLE);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop      = 1'b0;
        load_dest = cur_dest;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (dest_ok) begin
                        load      = 1'b1;
                        load_dest = SRC_AXIS_tdest;
                        if (!SRC_AXIS_tlast) state_nxt = ROUTE;
                    end else begin
                        drop = 1'b1;
                        if (!SRC_AXIS_tlast) state_nxt = DRAIN;
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (SRC_AXIS_tlast) state_nxt = IDLE;
                end
            end
            DRAIN: begin
                if (accept) begin
                    drop = 1'b1;
                    if (SRC_AXIS_tlast) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cur_dest  <= '0;
            out_valid <= 1'b0;
            out_dest  <= '0;
            out_data  <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                cur_dest  <= load_dest;
                out_valid <= 1'b1;
                out_dest  <= load_dest;
                out_data  <= SRC_AXIS_tdata;
            end else if (fire) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_count <= '0;
        end else if (drop && (drop_count != CNT_MAX)) begin
            drop_count <= drop_count + CNT_WIDTH'(1);
        end
    end

`ifdef MM2S_ROUTER_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt [NUM_FIFOS];

    // A packet is counted when its tlast beat enters the output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_FIFOS; i++) pkt_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                if (load && SRC_AXIS_tlast && (load_dest == AXIS_DEST_WIDTH'(i)) &&
                    (pkt_cnt[i] != CNT_MAX)) begin
                    pkt_cnt[i] <= pkt_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_pkt_count
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = pkt_cnt[g];
    end
`else
    assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_mm2s_packet_router.sv
// Directed bench for mm2s_packet_router (default parameters); expectations hand-derived per cycle.
module tb_mm2s_packet_router;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] tdata;
    logic [3:0]  tdest;
    logic        tlast;
    logic        tvalid;
    logic        tready;
    logic [3:0]  fifo_wren;
    logic [3:0]  fifo_full;
    logic [31:0] fifo_data;
    logic        busy;
    logic [15:0] drop_count;
    logic [63:0] pkt_count;

    int vectors = 0;
    int miscompares = 0;

    mm2s_packet_router dut (
        .clk             (clk),
        .rstn            (rstn),
        .SRC_AXIS_tdata  (tdata),
        .SRC_AXIS_tdest  (tdest),
        .SRC_AXIS_tlast  (tlast),
        .SRC_AXIS_tvalid (tvalid),
        .SRC_AXIS_tready (tready),
        .fifo_wren       (fifo_wren),
        .fifo_full       (fifo_full),
        .fifo_data       (fifo_data),
        .busy            (busy),
        .drop_count      (drop_count),
        .pkt_count       (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [3:0] dst, input logic l);
        tvalid = v;
        tdata  = d;
        tdest  = dst;
        tlast  = l;
    endtask

    function automatic logic [15:0] exp_pkt(input int n);
`ifdef MM2S_ROUTER_STATS_EN
        return 16'(n);
`else
        return 16'(0 * n);
`endif
    endfunction

    task automatic test_reset();
        rstn = 1'b0; fifo_full = '0;
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        #12;
        vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL reset_wren got %b want 0000", fifo_wren); end
        vectors++; if (fifo_data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", fifo_data); end
        vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL reset_tready got %b want 1", tready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (drop_count !== 16'h0) begin miscompares++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        vectors++; if (pkt_count !== 64'h0) begin miscompares++; $display("FAIL reset_pkt got %h want 0", pkt_count); end
        @(negedge clk);
        rstn = 1'b1;
        tick();
    endtask

    // 4-beat packet to sink 2; chg_dest re-drives beat index 2 with tdest=0.
    task automatic test_route(input string nm, input logic chg_dest, input int exp_cnt);
        logic [31:0] d [4];
        for (int b = 0; b < 4; b++) d[b] = 32'hA000_0010 + 32'(b) + (chg_dest ? 32'h100 : 32'h0);
        for (int b = 0; b < 4; b++) begin
            drive(1'b1, d[b], (chg_dest && b == 2) ? 4'd0 : 4'd2, b == 3);
            #1;
            vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL %s_tready b%0d got %b want 1", nm, b, tready); end
            vectors++; if (busy !== (b != 0)) begin miscompares++; $display("FAIL %s_busy b%0d got %b want %b", nm, b, busy, b != 0); end
            if (b == 0) begin
                vectors++; if (fifo_wren !== 4'b0000) begin miscompares++; $display("FAIL %s_wren b%0d got %b want 0000", nm, b, fifo_wren); end
            end else begin
                vectors++; if (fifo_wren !== 4'b0100) begin miscompares++; $display("FAIL %s_wren b%0d got %b want 0100", nm, b, fifo_wren); end
                vectors++; if (fifo_data !== d[b-1]) begin miscompares++; $display("FAIL %s_data b%0d got %h want %h", nm, b, fifo_data, d[b-1]); end
            end
            tick();
        end
        drive(1'b0, 32'h0, 4'h0, 1'b0);
        #1;
        vectors++; if (fifo_wren !== 4'b0100) begin miscompares++; $display("FAIL %s_wren_last got %b want 0100", nm, fifo_wren); end
        vectors++; if (fifo_data !== d[3]) begin miscompares++; $display("FAIL %s_data_last got %h want %h", nm, fifo_data, d[3]); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_busy_end got %b want 0", nm, busy); end
        tick();
        vectors++; if (fifo_wren !== 4'b0000) begin miscompares++; $display("FAIL %s_wren_idle got %b want 0000", nm, fifo_wren); end
        vectors++; if (pkt_count[32 +: 16] !== exp_pkt(exp_cnt)) begin miscompares++; $display("FAIL %s_pkt2 got %0d want %0d", nm, pkt_count[32 +: 16], exp_pkt(exp_cnt)); end
    endtask

    task automatic test_full_stall();
        int          drv  [11] = '{0, 1, 2, 2, 2, 2, 2, 2, 3, -1, -1};
        logic        full [11] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        logic        trdy [11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        logic        wr   [11] = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        int          dat  [11] = '{-1, 0, 1, 1, 1, 1, 1, 1, 2, 3, -1};
        for (int c = 0; c < 11; c++) begin
            if (drv[c] >= 0) drive(1'b1, 32'hB000_0000 + 32'(drv[c]), 4'd1, drv[c] == 3);
            else             drive(1'b0, 32'h0, 4'd0, 1'b0);
            fifo_full = {2'b00, full[c], 1'b0};
            #1;
            vectors++; if (tready !== trdy[c]) begin miscompares++; $display("FAIL stall_tready c%0d got %b want %b", c, tready, trdy[c]); end
            vectors++; if (fifo_wren !== {2'b00, wr[c], 1'b0}) begin miscompares++; $display("FAIL stall_wren c%0d got %b want %b", c, fifo_wren, {2'b00, wr[c], 1'b0}); end
            if (dat[c] >= 0) begin
                vectors++; if (fifo_data !== 32'hB000_0000 + 32'(dat[c])) begin miscompares++; $display("FAIL stall_data c%0d got %h want %h", c, fifo_data, 32'hB000_0000 + 32'(dat[c])); end
            end
            tick();
        end
        fifo_full = '0;
        vectors++; if (pkt_count[16 +: 16] !== exp_pkt(1)) begin miscompares++; $display("FAIL stall_pkt1 got %0d want %0d", pkt_count[16 +: 16], exp_pkt(1)); end
    endtask

    task automatic test_drain();
        for (int b = 0; b < 3; b++) begin
            drive(1'b1, 32'hD000_0000 + 32'(b), 4'd9, b == 2);
            #1;
            vectors++; if (busy !== (b != 0)) begin miscompares++; $display("FAIL drain_busy b%0d got %b want %b", b, busy, b != 0); end
            vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL drain_tready b%0d got %b want 1", b, tready); end
            vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL drain_wren b%0d got %b want 0000", b, fifo_wren); end
            tick();
        end
        drive(1'b1, 32'hE000_0000, 4'd0, 1'b1);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL drain_busy_after got %b want 0", busy); end
        vectors++; if (drop_count !== 16'd3) begin miscompares++; $display("FAIL drain_count got %0d want 3", drop_count); end
        vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL drain_wren_e0 got %b want 0000", fifo_wren); end
        tick();
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        #1;
        vectors++; if (fifo_wren !== 4'b0001) begin miscompares++; $display("FAIL drain_e0_wren got %b want 0001", fifo_wren); end
        vectors++; if (fifo_data !== 32'hE000_0000) begin miscompares++; $display("FAIL drain_e0_data got %h want E0000000", fifo_data); end
        tick();
        vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL drain_e0_once got %b want 0000", fifo_wren); end
        vectors++; if (drop_count !== 16'd3) begin miscompares++; $display("FAIL drain_count_hold got %0d want 3", drop_count); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) drive(1'b1, 32'hF000_0000 + 32'(c), 4'(c), 1'b1);
            else       drive(1'b0, 32'h0, 4'd0, 1'b0);
            #1;
            vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy c%0d got %b want 0", c, busy); end
            vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL b2b_tready c%0d got %b want 1", c, tready); end
            if (c >= 1 && c <= 4) begin
                vectors++; if (fifo_wren !== 4'(1 << (c - 1))) begin miscompares++; $display("FAIL b2b_wren c%0d got %b want %b", c, fifo_wren, 4'(1 << (c - 1))); end
                vectors++; if (fifo_data !== 32'hF000_0000 + 32'(c - 1)) begin miscompares++; $display("FAIL b2b_data c%0d got %h want %h", c, fifo_data, 32'hF000_0000 + 32'(c - 1)); end
            end else begin
                vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL b2b_wren c%0d got %b want 0000", c, fifo_wren); end
            end
            tick();
        end
        vectors++; if (pkt_count[48 +: 16] !== exp_pkt(1)) begin miscompares++; $display("FAIL b2b_pkt3 got %0d want %0d", pkt_count[48 +: 16], exp_pkt(1)); end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 32'hC000_0000, 4'd3, 1'b0);
        tick();
        drive(1'b1, 32'hC000_0001, 4'd3, 1'b0);
        #1;
        vectors++; if (fifo_wren !== 4'b1000) begin miscompares++; $display("FAIL mrst_wren0 got %b want 1000", fifo_wren); end
        tick();
        drive(1'b1, 32'hC000_0002, 4'd2, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL mrst_wren got %b want 0000", fifo_wren); end
        vectors++; if (fifo_data !== 32'h0) begin miscompares++; $display("FAIL mrst_data got %h want 0", fifo_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mrst_busy got %b want 0", busy); end
        vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL mrst_tready got %b want 1", tready); end
        vectors++; if (drop_count !== 16'h0) begin miscompares++; $display("FAIL mrst_drop got %0d want 0", drop_count); end
        vectors++; if (pkt_count !== 64'h0) begin miscompares++; $display("FAIL mrst_pkt got %h want 0", pkt_count); end
        tick();
        rstn = 1'b1;
        #2;
        vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL mrst_wren_rel got %b want 0000", fifo_wren); end
        tick();
        drive(1'b1, 32'hC000_0003, 4'd1, 1'b1);
        #1;
        vectors++; if (fifo_wren !== 4'b0100) begin miscompares++; $display("FAIL mrst_new_wren got %b want 0100", fifo_wren); end
        vectors++; if (fifo_data !== 32'hC000_0002) begin miscompares++; $display("FAIL mrst_new_data got %h want C0000002", fifo_data); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mrst_new_busy got %b want 1", busy); end
        tick();
        drive(1'b0, 32'h0, 4'd0, 1'b0);
        #1;
        vectors++; if (fifo_wren !== 4'b0100) begin miscompares++; $display("FAIL mrst_tail_wren got %b want 0100", fifo_wren); end
        vectors++; if (fifo_data !== 32'hC000_0003) begin miscompares++; $display("FAIL mrst_tail_data got %h want C0000003", fifo_data); end
        tick();
        vectors++; if (fifo_wren !== 4'b0) begin miscompares++; $display("FAIL mrst_idle_wren got %b want 0000", fifo_wren); end
        vectors++; if (pkt_count[32 +: 16] !== exp_pkt(1)) begin miscompares++; $display("FAIL mrst_pkt2 got %0d want %0d", pkt_count[32 +: 16], exp_pkt(1)); end
    endtask

    initial begin
        test_reset();
        test_route("route", 1'b0, 1);
        test_route("chgdest", 1'b1, 2);
        test_full_stall();
        test_drain();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
